io_write_scoreboard: RTL and testbench

Synthesizable run-time checker for the 8-bit microcontroller's I/O port bus, sitting beside `computer` and snooping `io_addr`/`io_data`/`io_we`/`io_oe`. It holds a queue of expected port writes, compares each real write in order, detects the `BRA *` halt idiom, and runs a watchdog. It reports pass/fail plus error and cycle counters for on-board self-test and regression. Widths, queue depth and halt pattern are parameters.

---
 rtl/io_write_scoreboard.sv | 205 ++++++++++++++++++++
 tb/tb_io_write_scoreboard.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/io_write_scoreboard.sv
// Run-time checker for the MCU I/O port bus: compares snooped port writes against
// a queue of expected writes, detects the branch-to-self halt, and runs a watchdog.
module io_write_scoreboard #(
    parameter int          DATA_W   = 8,
    parameter int          ADDR_W   = 4,
    parameter int          DEPTH    = 16,
    parameter int          CNT_W    = 16,
    parameter int          ERR_W    = 8,
    parameter logic [7:0]  HALT_OP  = 8'h20,
    parameter logic [7:0]  HALT_ARG = 8'hFE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CNT_W-1:0]          wdog_limit,
    input  logic                      exp_valid,
    output logic                      exp_ready,
    input  logic [ADDR_W-1:0]         exp_addr,
    input  logic [DATA_W-1:0]         exp_data,
    input  logic [ADDR_W-1:0]         io_addr,
    input  logic [DATA_W-1:0]         io_data,
    input  logic                      io_we,
    input  logic                      io_oe,
    input  logic [DATA_W-1:0]         ir,
    input  logic [DATA_W-1:0]         op_byte,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [ERR_W-1:0]          error_cnt,
    output logic [CNT_W-1:0]          write_cnt,
    output logic [CNT_W-1:0]          cycle_cnt,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic [1:0]                err_code,
    output logic [ADDR_W-1:0]         err_addr,
    output logic [DATA_W-1:0]         err_data,
    output logic [DATA_W-1:0]         err_exp
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALTED  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t              state_r, state_next_s;
    logic [ADDR_W-1:0]   q_addr_r [DEPTH];
    logic [DATA_W-1:0]   q_data_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r, rd_ptr_inc_s;
    logic [PTR_W:0]      count_r, count_next_s, left_s;
    logic [CNT_W-1:0]    wdog_limit_r, cyc_inc_s;
    logic                exp_ready_r;
    logic                run_s, start_s, wr_evt_s, push_s, pop_s, halt_s, wdog_s;
    logic                mism_s, unexp_s, missing_s;
    logic [1:0]          err_inc_s;
    logic [ERR_W:0]      err_sum_s;
    logic [ERR_W-1:0]    err_cnt_next_s;

    // Event decode, queue bookkeeping and error accounting for this cycle
    always_comb begin
        run_s        = (state_r == ST_RUN);
        start_s      = start & ~run_s;
        wr_evt_s     = run_s & io_we & io_oe;
        push_s       = exp_valid & exp_ready_r;
        pop_s        = wr_evt_s & (count_r != '0);
        unexp_s      = wr_evt_s & (count_r == '0);
        mism_s       = pop_s & ((io_addr != q_addr_r[rd_ptr_r]) | (io_data != q_data_r[rd_ptr_r]));
        halt_s       = run_s & (ir == DATA_W'(HALT_OP)) & (op_byte == DATA_W'(HALT_ARG));
        rd_ptr_inc_s = rd_ptr_r + PTR_W'(1);
        left_s       = count_r - {{PTR_W{1'b0}}, pop_s};
        missing_s    = halt_s & (left_s != '0);
        cyc_inc_s    = cycle_cnt + CNT_W'(1);
        wdog_s       = run_s & ~halt_s & (wdog_limit_r != '0) & (cyc_inc_s == wdog_limit_r);
        count_next_s = count_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
        err_inc_s    = {1'b0, mism_s | unexp_s} + {1'b0, missing_s};
        err_sum_s    = {1'b0, error_cnt} + {{(ERR_W-1){1'b0}}, err_inc_s};
        if (start_s) begin
            err_cnt_next_s = '0;
        end else if (err_sum_s[ERR_W]) begin
            err_cnt_next_s = '1;
        end else begin
            err_cnt_next_s = err_sum_s[ERR_W-1:0];
        end
    end

    // Next-state logic; a halt takes priority over a same-cycle watchdog expiry
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_s) begin
                    state_next_s = ST_HALTED;
                end else if (wdog_s) begin
                    state_next_s = ST_TIMEOUT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == ST_RUN);
            done    <= (state_next_s == ST_HALTED) | (state_next_s == ST_TIMEOUT);
            pass    <= (state_next_s == ST_HALTED) & (err_cnt_next_s == '0);
            timeout <= (state_next_s == ST_TIMEOUT);
        end
    end

    // Expected-write FIFO; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr_r[i] <= '0;
                q_data_r[i] <= '0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            exp_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                q_addr_r[wr_ptr_r] <= exp_addr;
                q_data_r[wr_ptr_r] <= exp_data;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r     <= count_next_s;
            exp_ready_r <= (count_next_s != FULL_CNT);
        end
    end

    // Run counters, watchdog limit and first-error capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_limit_r <= '0;
            cycle_cnt    <= '0;
            write_cnt    <= '0;
            error_cnt    <= '0;
            err_code     <= 2'd0;
            err_addr     <= '0;
            err_data     <= '0;
            err_exp      <= '0;
        end else if (start_s) begin
            wdog_limit_r <= wdog_limit;
            cycle_cnt    <= '0;
            write_cnt    <= '0;
            error_cnt    <= '0;
            err_code     <= 2'd0;
            err_addr     <= '0;
            err_data     <= '0;
            err_exp      <= '0;
        end else if (run_s) begin
            cycle_cnt <= cyc_inc_s;
            write_cnt <= wr_evt_s ? write_cnt + CNT_W'(1) : write_cnt;
            error_cnt <= err_cnt_next_s;
            // A bus error in the same cycle as a missing-write halt wins the capture
            if (err_code == 2'd0 && (mism_s || unexp_s)) begin
                err_code <= mism_s ? 2'd1 : 2'd2;
                err_addr <= io_addr;
                err_data <= io_data;
                err_exp  <= mism_s ? q_data_r[rd_ptr_r] : '0;
            end else if (err_code == 2'd0 && missing_s) begin
                err_code <= 2'd3;
                err_addr <= pop_s ? q_addr_r[rd_ptr_inc_s] : q_addr_r[rd_ptr_r];
                err_data <= '0;
                err_exp  <= pop_s ? q_data_r[rd_ptr_inc_s] : q_data_r[rd_ptr_r];
            end else begin
                err_code <= err_code;
            end
        end else begin
            cycle_cnt <= cycle_cnt;
        end
    end

    assign exp_ready = exp_ready_r;
    assign q_count   = count_r;

endmodule

// File: tb/tb_io_write_scoreboard.sv
// Directed-vector bench for io_write_scoreboard with default parameters.
module tb_io_write_scoreboard;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] wdog_limit = 16'd0;
    logic        exp_valid = 1'b0;
    logic        exp_ready;
    logic [3:0]  exp_addr = 4'd0;
    logic [7:0]  exp_data = 8'd0;
    logic [3:0]  io_addr = 4'd0;
    logic [7:0]  io_data = 8'd0;
    logic        io_we = 1'b0;
    logic        io_oe = 1'b0;
    logic [7:0]  ir = 8'd0;
    logic [7:0]  op_byte = 8'd0;
    logic        busy, done, pass, timeout;
    logic [7:0]  error_cnt;
    logic [15:0] write_cnt, cycle_cnt;
    logic [4:0]  q_count;
    logic [1:0]  err_code;
    logic [3:0]  err_addr;
    logic [7:0]  err_data, err_exp;

    int n_checks = 0;
    int n_pass   = 0;

    io_write_scoreboard dut (
        .clk(clk), .reset(reset), .start(start), .wdog_limit(wdog_limit),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_addr(exp_addr), .exp_data(exp_data),
        .io_addr(io_addr), .io_data(io_data), .io_we(io_we), .io_oe(io_oe),
        .ir(ir), .op_byte(op_byte), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .error_cnt(error_cnt), .write_cnt(write_cnt), .cycle_cnt(cycle_cnt), .q_count(q_count),
        .err_code(err_code), .err_addr(err_addr), .err_data(err_data), .err_exp(err_exp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        exp_valid = 1'b1; exp_addr = a; exp_data = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] lim);
        start = 1'b1; wdog_limit = lim;
        tick();
        start = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic hlt);
        io_we = 1'b1; io_oe = 1'b1; io_addr = a; io_data = d;
        if (hlt) begin ir = 8'h20; op_byte = 8'hFE; end
        tick();
        io_we = 1'b0; io_oe = 1'b0; ir = 8'h00; op_byte = 8'h00;
    endtask

    task automatic halt();
        ir = 8'h20; op_byte = 8'hFE;
        tick();
        ir = 8'h00; op_byte = 8'h00;
    endtask

    initial begin
        tick();
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_ready", exp_ready, 1); chk("rst_qcount", q_count, 0);
        chk("rst_errcnt", error_cnt, 0);
        reset = 1'b1;
        tick();

        // clean run: two matching writes then halt
        push(4'd1, 8'h01); push(4'd1, 8'h00);
        chk("pre_qcount", q_count, 2);
        do_start(16'd100);
        chk("t1_busy", busy, 1);
        wr(4'd1, 8'h01, 1'b0); wr(4'd1, 8'h00, 1'b0); halt();
        chk("t1_done", done, 1);       chk("t1_pass", pass, 1);
        chk("t1_errcnt", error_cnt, 0); chk("t1_wcnt", write_cnt, 2);
        chk("t1_qcount", q_count, 0);  chk("t1_cycles", cycle_cnt, 3);
        chk("t1_busy_off", busy, 0);

        // data mismatch
        push(4'd1, 8'h05);
        do_start(16'd100);
        wr(4'd1, 8'h07, 1'b0);
        chk("t2_code", err_code, 1);   chk("t2_addr", err_addr, 1);
        chk("t2_data", err_data, 8'h07); chk("t2_exp", err_exp, 8'h05);
        halt();
        chk("t2_pass", pass, 0);       chk("t2_errcnt", error_cnt, 1);

        // unexpected write on empty queue
        do_start(16'd100);
        chk("t3_clr_code", err_code, 0);
        wr(4'd3, 8'hAA, 1'b0);
        chk("t3_code", err_code, 2);   chk("t3_addr", err_addr, 3);
        chk("t3_data", err_data, 8'hAA); chk("t3_exp", err_exp, 0);
        halt();
        chk("t3_errcnt", error_cnt, 1); chk("t3_pass", pass, 0);

        // missing writes at halt
        push(4'd2, 8'h11); push(4'd2, 8'h22); push(4'd2, 8'h33);
        do_start(16'd100);
        wr(4'd2, 8'h11, 1'b0); halt();
        chk("t4_code", err_code, 3);   chk("t4_errcnt", error_cnt, 1);
        chk("t4_qcount", q_count, 2);  chk("t4_addr", err_addr, 2);
        chk("t4_exp", err_exp, 8'h22); chk("t4_data", err_data, 0);
        // leftover queue survives into the next run; last write coincides with halt
        do_start(16'd100);
        wr(4'd2, 8'h22, 1'b0); wr(4'd2, 8'h33, 1'b1);
        chk("t4b_pass", pass, 1);      chk("t4b_qcount", q_count, 0);

        // watchdog
        do_start(16'd20);
        for (int i = 0; i < 19; i++) tick();
        chk("t5_cyc19", cycle_cnt, 19); chk("t5_not_to", timeout, 0);
        tick();
        chk("t5_timeout", timeout, 1); chk("t5_cyc20", cycle_cnt, 20);
        chk("t5_done", done, 1);       chk("t5_errcnt", error_cnt, 0);
        tick(); tick();
        chk("t5_hold", cycle_cnt, 20);
        do_start(16'd5);
        for (int i = 0; i < 4; i++) tick();
        halt();
        chk("t5b_halted", pass, 1);    chk("t5b_to", timeout, 0);

        // fill to 16, 17th push dropped
        for (int i = 0; i < 17; i++) push(4'(i), 8'h80 + 8'(i));
        chk("t6_full_ready", exp_ready, 0); chk("t6_qcount", q_count, 16);
        do_start(16'd0);
        for (int i = 0; i < 16; i++) wr(4'(i), 8'h80 + 8'(i), i == 15);
        chk("t6_pass", pass, 1);       chk("t6_ready", exp_ready, 1);
        chk("t6_qcount0", q_count, 0); chk("t6_wcnt", write_cnt, 16);

        // error counter saturation, watchdog disabled
        do_start(16'd0);
        io_we = 1'b1; io_oe = 1'b1; io_addr = 4'd9; io_data = 8'h55;
        for (int i = 0; i < 300; i++) tick();
        io_we = 1'b0; io_oe = 1'b0;
        chk("t7_errsat", error_cnt, 255); chk("t7_wcnt", write_cnt, 300);
        chk("t7_busy", busy, 1);

        // asynchronous reset mid-run flushes everything
        push(4'd1, 8'h01);
        chk("t8_pre_q", q_count, 1);
        reset = 1'b0;
        #1;
        chk("t8_busy", busy, 0);       chk("t8_errcnt", error_cnt, 0);
        chk("t8_wcnt", write_cnt, 0);  chk("t8_cyc", cycle_cnt, 0);
        chk("t8_q", q_count, 0);       chk("t8_code", err_code, 0);
        chk("t8_ready", exp_ready, 1);
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
